// File: rtl/image_ram_loader.sv
// Frame loader: takes a valid/ready byte stream and writes it in raster
// order into the image RAM write port.
//
// Ports
//   iClk, iRst        clock, asynchronous active-high reset
//   iStart, iAbort    begin a frame load / abandon a load in progress
//   iData, iValid     pixel byte stream in
//   oReady            byte accepted this cycle when iValid is also high
//   oWrAddr, oWrData  RAM write port, qualified by oWrEn (1-cycle latency)
//   oBusy             load or flush in progress
//   oDone             1-cycle pulse when the frame is fully written
//   oReaderEn         level enable to the pixel reader, frame resident
//   oChecksum         sum of accepted pixels, mod 2**16
module image_ram_loader #(
    parameter int ADDR_WIDTH  = 14,
    parameter int DATA_WIDTH  = 8,
    parameter int PIXEL_COUNT = 16384
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iStart,
    input  logic                  iAbort,
    input  logic [DATA_WIDTH-1:0] iData,
    input  logic                  iValid,
    output logic                  oReady,
    output logic [ADDR_WIDTH-1:0] oWrAddr,
    output logic [DATA_WIDTH-1:0] oWrData,
    output logic                  oWrEn,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oReaderEn,
    output logic [15:0]           oChecksum
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    // One extra bit so the counter can never wrap by overflow.
    localparam int            CW       = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(PIXEL_COUNT - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic          accept;
    logic          load_entry;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An abort in LOAD suppresses a coincident accept.
    always_comb begin
        state_next = state;
        load_entry = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (iStart) begin
                    state_next = LOAD;
                    load_entry = 1'b1;
                end
            end
            LOAD: begin
                if (iAbort) begin
                    state_next = IDLE;
                end else if (iValid) begin
                    accept = 1'b1;
                    if (count == LAST_IDX) begin
                        state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                state_next = DONE;
            end
            DONE: begin
                if (iStart) begin
                    state_next = LOAD;
                    load_entry = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            count     <= '0;
            oChecksum <= '0;
            oWrEn     <= 1'b0;
            oWrAddr   <= '0;
            oWrData   <= '0;
            oDone     <= 1'b0;
        end else begin
            oWrEn <= accept;
            oDone <= (state == FLUSH);
            if (accept) begin
                oWrAddr <= count[ADDR_WIDTH-1:0];
                oWrData <= iData;
            end
            if (load_entry) begin
                count     <= '0;
                oChecksum <= '0;
            end else if (accept) begin
                count     <= count + 1'b1;
                oChecksum <= oChecksum + 16'(iData);
            end
        end
    end

    // Plain decodes of the state register, independent of iValid.
    assign oReady    = (state == LOAD);
    assign oBusy     = (state == LOAD) || (state == FLUSH);
    assign oReaderEn = (state == DONE);

endmodule

// File: tb/tb_image_ram_loader.sv
// Self-checking bench for image_ram_loader: random streams compared every
// cycle against a behavioural frame-load model, plus literal spot checks.
module tb_image_ram_loader;

    localparam int AW = 14;
    localparam int DW = 8;
    localparam int PC = 16384;

    logic          clk;
    logic          iRst;
    logic          iStart;
    logic          iAbort;
    logic [DW-1:0] iData;
    logic          iValid;
    logic          oReady;
    logic [AW-1:0] oWrAddr;
    logic [DW-1:0] oWrData;
    logic          oWrEn;
    logic          oBusy;
    logic          oDone;
    logic          oReaderEn;
    logic [15:0]   oChecksum;

    image_ram_loader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .PIXEL_COUNT(PC)
    ) dut (
        .iClk     (clk),
        .iRst     (iRst),
        .iStart   (iStart),
        .iAbort   (iAbort),
        .iData    (iData),
        .iValid   (iValid),
        .oReady   (oReady),
        .oWrAddr  (oWrAddr),
        .oWrData  (oWrData),
        .oWrEn    (oWrEn),
        .oBusy    (oBusy),
        .oDone    (oDone),
        .oReaderEn(oReaderEn),
        .oChecksum(oChecksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 loading, 2 last write in
    // flight, 3 frame resident. n counts accepted bytes of this load.
    int          phase = 0;
    int          n     = 0;
    int unsigned sum_m = 0;
    bit          e_wr  = 0;
    bit          e_done = 0;
    int          e_addr = 0;
    int          e_data = 0;

    always @(posedge clk or posedge iRst) begin
        if (iRst) begin
            phase = 0; n = 0; sum_m = 0; e_wr = 0; e_done = 0;
        end else begin
            e_wr = 0;
            e_done = 0;
            case (phase)
                0, 3: begin
                    if (iStart) begin
                        phase = 1; n = 0; sum_m = 0;
                    end
                end
                1: begin
                    if (iAbort) begin
                        phase = 0;
                    end else if (iValid) begin
                        e_wr = 1; e_addr = n; e_data = int'(iData);
                        sum_m += iData;
                        n++;
                        if (n == PC) phase = 2;
                    end
                end
                default: begin
                    phase = 3; e_done = 1;
                end
            endcase
        end
    end

    logic [7:0] shadow [0:PC-1];
    int         wcount = 0;
    int         done_count = 0;

    always @(negedge clk) begin
        chk("ready", oReady, phase == 1);
        chk("busy", oBusy, phase == 1 || phase == 2);
        chk("reader_en", oReaderEn, phase == 3);
        chk("done", oDone, e_done);
        chk("wr_en", oWrEn, e_wr);
        if (e_wr) begin
            chk("wr_addr", oWrAddr, e_addr);
            chk("wr_data", oWrData, e_data);
        end
        chk("checksum", oChecksum, sum_m & 32'hFFFF);
        if (oWrEn === 1'b1) begin
            shadow[oWrAddr] = oWrData;
            wcount++;
        end
        if (oDone === 1'b1) done_count++;
    end

    task automatic pulse_start();
        iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
    endtask

    // Sends n bytes; vp = valid probability in eighths, sp = chance in
    // sixteenths of a stray iStart. kind 0: k&FF, 1: FF, 2: random.
    task automatic stream(input int cnt, input int kind, input int vp,
                          input int sp, output int unsigned sum);
        int sent = 0;
        int cyc = 0;
        logic [7:0] b;
        sum = 0;
        while (sent < cnt) begin
            if (cyc > cnt * 4 + 100) begin
                chk("stream_budget", 1, 0);
                break;
            end
            iValid = ($urandom_range(0, 7) < vp);
            iStart = ($urandom_range(0, 15) < sp);
            case (kind)
                0: b = 8'(sent);
                1: b = 8'hFF;
                default: b = 8'($urandom);
            endcase
            iData = iValid ? b : 8'($urandom);
            @(negedge clk);
            if (iValid) begin
                sent++;
                sum += b;
            end
            cyc++;
        end
        iValid = 1'b0;
        iStart = 1'b0;
    endtask

    task automatic check_ram(input string name, input int kind);
        int bad = 0;
        for (int k = 0; k < PC; k++) begin
            if (shadow[k] !== ((kind == 0) ? 8'(k) : 8'hFF)) bad++;
        end
        chk(name, bad, 0);
    endtask

    int unsigned s;

    initial begin
        iRst = 1'b1; iStart = 1'b0; iAbort = 1'b0;
        iData = '0; iValid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", oReady, 0);
        chk("rst_wr_en", oWrEn, 0);
        chk("rst_reader", oReaderEn, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_done", oDone, 0);
        chk("rst_sum", oChecksum, 0);
        #2 iRst = 1'b0;
        @(negedge clk);

        // Full frame, continuous stream.
        wcount = 0; done_count = 0;
        pulse_start();
        stream(PC, 0, 8, 0, s);
        chk("t1_last_wr", oWrEn, 1);
        chk("t1_last_addr", oWrAddr, PC - 1);
        chk("t1_no_early_done", oDone, 0);
        @(negedge clk);
        chk("t1_done", oDone, 1);
        chk("t1_reader", oReaderEn, 1);
        chk("t1_ready", oReady, 0);
        // 64 repeats of 0..255: 64 * 32640 = 0x1FE000, low 16 bits E000.
        chk("t1_sum", oChecksum, 16'hE000);
        repeat (3) @(negedge clk);
        chk("t1_writes", wcount, PC);
        chk("t1_done_count", done_count, 1);
        check_ram("t1_ram", 0);

        // Restart from DONE, then gappy stream with stray iStart.
        pulse_start();
        chk("t4_reader_off", oReaderEn, 0);
        chk("t4_sum_clr", oChecksum, 0);
        chk("t4_ready", oReady, 1);
        wcount = 0;
        stream(PC, 0, 7, 1, s);
        repeat (2) @(negedge clk);
        chk("t2_writes", wcount, PC);
        chk("t2_sum", oChecksum, 16'hE000);
        check_ram("t2_ram", 0);

        // Abort ignored while the frame is resident.
        iAbort = 1'b1;
        repeat (5) @(negedge clk);
        iAbort = 1'b0;
        chk("t5_reader", oReaderEn, 1);
        chk("t5_writes", wcount, PC);

        // Abort coincident with accept #101.
        wcount = 0;
        pulse_start();
        stream(100, 2, 8, 0, s);
        iValid = 1'b1; iData = 8'($urandom); iAbort = 1'b1;
        @(negedge clk);
        iValid = 1'b0; iAbort = 1'b0;
        @(negedge clk);
        chk("t3_writes", wcount, 100);
        chk("t3_sum", oChecksum, s & 32'hFFFF);
        chk("t3_reader", oReaderEn, 0);
        chk("t3_busy", oBusy, 0);
        chk("t3_ready", oReady, 0);

        // Reset mid-load, then a full all-FF reload.
        pulse_start();
        stream(5000, 1, 8, 0, s);
        iValid = 1'b1;
        #2 iRst = 1'b1;
        #1;
        chk("t6_wr_en", oWrEn, 0);
        chk("t6_ready", oReady, 0);
        chk("t6_busy", oBusy, 0);
        chk("t6_sum", oChecksum, 0);
        chk("t6_addr", oWrAddr, 0);
        chk("t6_data", oWrData, 0);
        @(negedge clk);
        iValid = 1'b0;
        #2 iRst = 1'b0;
        @(negedge clk);
        wcount = 0;
        pulse_start();
        stream(PC, 1, 8, 0, s);
        repeat (2) @(negedge clk);
        // 16384 * 255 = 0x3FC000, low 16 bits C000.
        chk("t6_full_sum", oChecksum, 16'hC000);
        chk("t6_writes", wcount, PC);
        chk("t6_reader", oReaderEn, 1);
        check_ram("t6_ram", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
